// File: rtl/seq_mult_rr_arbiter.sv
// seq_mult_rr_arbiter
//   Shares one unsigned sequential multiplier core between two requesters.
//   A request is granted round-robin. Its operands are latched and the core is
//   started with a one-cycle load pulse. The block then waits for the core's
//   done pulse, guarded by a watchdog. The result is returned with a one-cycle
//   acknowledge to the requester that was served.
//
// Ports
//   clk, rst                : clock (rising edge), synchronous active-high reset
//   req0/a0/b0, req1/a1/b1  : requester handshakes and operands
//   ack0, ack1              : one-cycle completion pulse per requester
//   res_valid               : one-cycle pulse marking new res_id/res_product/res_err
//   res_id                  : id of the requester being served
//   res_product             : core product, or 0 on timeout
//   res_err                 : watchdog timeout flag
//   busy                    : high in every state except IDLE
//   mul_load, mul_a, mul_b  : start pulse and latched operands to the core
//   mul_done, mul_product   : completion pulse and product from the core
module seq_mult_rr_arbiter #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic               res_valid,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_err,
  output logic               busy,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;      // 0: favour requester 0, 1: favour requester 1
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 id_q, id_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;
  logic                 gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      id_q    <= 1'b0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    id_d    = id_q;
    prod_d  = prod_q;
    err_d   = err_q;
    gnt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention is settled by the pointer; a lone request wins outright.
          gnt     = (req0 && req1) ? ptr_q : req1;
          id_d    = gnt;
          mul_a_d = gnt ? a1 : a0;
          mul_b_d = gnt ? b1 : b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done is tested first so a completion on the last watchdog cycle
        // still returns the real product.
        if (mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        ptr_d   = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign mul_load    = (state_q == ISSUE);
  assign res_valid   = (state_q == RESP);
  assign ack0        = res_valid & ~id_q;
  assign ack1        = res_valid &  id_q;
  assign res_id      = id_q;
  assign res_product = prod_q;
  assign res_err     = err_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule

// File: doc/seq_mult_rr_arbiter.md
Name: seq_mult_rr_arbiter

Overview:
- Shares one unsigned sequential multiplier core (load/done interface) between two requesters.
- Round-robin arbitration, operand capture, core start sequencing, done wait with watchdog timeout, and result return with per-requester acknowledge.
- Sits between two client blocks and a single WIDTH x WIDTH shift-add multiplier core.

Parameters:
- WIDTH, 6, operand width; product is 2*WIDTH.
- TIMEOUT, 16, maximum cycles spent in WAIT before the transaction is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held high until ack0.
- a0  in  WIDTH  requester 0 operand a; stable while req0 high.
- b0  in  WIDTH  requester 0 operand b; stable while req0 high.
- req1  in  1  requester 1 request; held high until ack1.
- a1  in  WIDTH  requester 1 operand a; stable while req1 high.
- b1  in  WIDTH  requester 1 operand b; stable while req1 high.
- ack0  out  1  one-cycle pulse: requester 0 transaction complete.
- ack1  out  1  one-cycle pulse: requester 1 transaction complete.
- res_valid  out  1  one-cycle pulse, coincident with ack0 or ack1.
- res_id  out  1  id of the served requester; valid with res_valid.
- res_product  out  2*WIDTH  result; valid with res_valid.
- res_err  out  1  timeout flag; valid with res_valid.
- busy  out  1  high in every state except IDLE.
- mul_load  out  1  one-cycle start pulse to the multiplier core.
- mul_a  out  WIDTH  latched operand a to the core.
- mul_b  out  WIDTH  latched operand b to the core.
- mul_done  in  1  one-cycle completion pulse from the core.
- mul_product  in  2*WIDTH  core product; valid when mul_done is high.

Behaviour:
Reset:
- Synchronous reset forces state IDLE.
- All outputs are 0: ack*, res_*, busy, mul_load, mul_a, mul_b.
- Watchdog counter cleared; priority pointer set to favour requester 0.
- Reset mid-transaction abandons it with no ack. Any later mul_done from the core is ignored.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Neither req high: stay.
- One req high: grant it.
- Both high: grant the requester named by the priority pointer.
- On grant: latch a/b into mul_a/mul_b and the id into res_id; go to ISSUE.

ISSUE:
- mul_load=1 for exactly this cycle; go to WAIT with the counter set to 0.
- mul_a/mul_b stay stable from ISSUE through RESP.

WAIT:
- Counter increments each cycle.
- mul_done=1: latch mul_product into res_product, res_err=0; go to RESP.
- Counter reaches TIMEOUT-1 with no done: res_product=0, res_err=1; go to RESP.
- If done and timeout occur in the same cycle, done wins.

RESP:
- res_valid=1 and the matching ack=1 for exactly one cycle.
- Pointer moves to favour the other requester; go to IDLE.

Outputs and timing:
- res_* hold their values until the next RESP. Only res_valid marks new data.
- mul_done outside WAIT is ignored.
- Latency: req seen in IDLE at cycle N -> mul_load at N+1 -> core done at cycle D -> res_valid/ack at D+1.
- Back-to-back transactions: minimum 4 cycles of overhead plus core latency.

Handshake:
- A requester must drop req on the edge after its ack. If req is still high in the following IDLE cycle, it is a new transaction.
- req dropped before ack (protocol violation): the transaction still completes and still acks.
- Fairness: with both requesters continuously requesting, grants strictly alternate.

Arithmetic:
- Operands unsigned. The product is passed through unmodified from the core; no width truncation inside the block.

Test Plan:
- After reset, req0 with a0=2, b0=2; mock core done 7 cycles after load -> res_product=4, res_id=0, res_err=0, ack0 single pulse, ack1 never.
- req0 (a0=17, b0=16) and req1 (a1=24, b1=42) raised in the same cycle after reset -> first result 272/id0, then 1008/id1; mul_load pulses exactly twice; operands never mixed.
- Both requesters re-request continuously for 4 transactions, with requester 1 using a1=49, b1=43 -> grant order 0,1,0,1; every id1 result is 2107.
- Mock core never asserts mul_done -> res_valid with res_err=1, res_product=0 exactly TIMEOUT cycles after entering WAIT; the next transaction then completes normally.
- rst asserted during WAIT, then a stray mul_done after reset -> no ack, no res_valid, busy=0, state IDLE; the next req0 is served normally with the pointer favouring requester 0.
- mul_done pulsed while in IDLE, and again simultaneously with the timeout cycle -> the IDLE pulse is ignored; the simultaneous case yields res_err=0 with the core product.
